// File: rtl/feistel_cipher_iter.sv
// feistel_cipher_iter: iterative Feistel cipher, one round per clock, valid/ready on both sides
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous active-low reset
//   in_valid   producer offers in_data/in_key/in_mode
//   in_ready   block accepts a new word (IDLE only)
//   in_data    plaintext (encrypt) or ciphertext (decrypt), WIDTH bits
//   in_key     block key, WIDTH bits
//   in_mode    0 = encrypt, 1 = decrypt
//   out_valid  out_data holds a finished result
//   out_ready  consumer takes the result
//   out_data   registered result word, WIDTH bits
// Optional: define FEISTEL_KEY_WHITEN_EN to XOR the key into the input and the output.
module feistel_cipher_iter #(
    parameter int WIDTH  = 8,
    parameter int ROUNDS = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] in_key,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    localparam int HALF = WIDTH / 2;
    localparam int LO   = HALF / 2;
    localparam int HI   = HALF - LO;
    localparam int CW   = ROUNDS > 1 ? $clog2(ROUNDS) : 1;
    localparam logic [CW-1:0] LAST = CW'(ROUNDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic             live_q, live_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] lr_q, lr_d;
    logic [WIDTH-1:0] key_q, key_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] out_q, out_d;

    logic [HALF-1:0]  l, r, f;
    logic [WIDTH-1:0] rk, x, wd, load, res, fin;
    logic [LO:0]      lo;
    logic [HI-1:0]    hi_0, hi_1;
    int               j;

    // Round datapath: key schedule, expansion, carry-select F and whitening.
    always_comb begin
        j    = mode_q ? ROUNDS - 1 - int'(cnt_q) : int'(cnt_q);
        rk   = (key_q << (j % WIDTH)) | (key_q >> (WIDTH - (j % WIDTH)));
        l    = lr_q[WIDTH-1:HALF];
        r    = lr_q[HALF-1:0];
        x    = {r[HALF-2:0], r[HALF-1], r} ^ rk;
        lo   = {1'b0, x[HALF+LO-1:HALF]} + {1'b0, x[LO-1:0]} + {{LO{1'b0}}, rk[0]};
        hi_0 = x[WIDTH-1:HALF+LO] + x[HALF-1:LO];
        hi_1 = x[WIDTH-1:HALF+LO] + x[HALF-1:LO] + HI'(1);
        f    = {lo[LO] ? hi_1 : hi_0, lo[LO-1:0]};
        // Result after the current round, halves unswapped for decrypt.
        res  = mode_q ? {l ^ f, r} : {r, l ^ f};
`ifdef FEISTEL_KEY_WHITEN_EN
        wd   = in_data ^ in_key;
        fin  = res ^ key_q;
`else
        wd   = in_data;
        fin  = res;
`endif
        load = in_mode ? {wd[HALF-1:0], wd[WIDTH-1:HALF]} : wd;
    end

    always_comb begin
        state_d   = state_q;
        live_d    = 1'b1;
        cnt_d     = cnt_q;
        lr_d      = lr_q;
        key_d     = key_q;
        mode_d    = mode_q;
        out_d     = out_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                // live_q holds in_ready low until the first edge after reset.
                in_ready = live_q;
                if (in_valid && live_q) begin
                    lr_d    = load;
                    key_d   = in_key;
                    mode_d  = in_mode;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                lr_d  = {r, l ^ f};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    out_d   = fin;
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            live_q  <= 1'b0;
            cnt_q   <= '0;
            lr_q    <= '0;
            key_q   <= '0;
            mode_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            live_q  <= live_d;
            cnt_q   <= cnt_d;
            lr_q    <= lr_d;
            key_q   <= key_d;
            mode_q  <= mode_d;
            out_q   <= out_d;
        end
    end

    assign out_data = out_q;
endmodule

// File: tb/tb_feistel_cipher_iter.sv
// tb_feistel_cipher_iter: directed and round-trip checks on three parameterisations
module tb_feistel_cipher_iter;
`ifdef FEISTEL_KEY_WHITEN_EN
    localparam bit WH = 1'b1;
`else
    localparam bit WH = 1'b0;
`endif
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  iv = '0, md = '0, ordy = '0;
    logic [15:0] din [3];
    logic [15:0] key [3];
    wire  [2:0]  ir, ov;
    wire  [7:0]  o0, o1;
    wire  [15:0] o2;
    int          n_chk = 0, n_pass = 0;

    always #5 clock = ~clock;

    feistel_cipher_iter #(.WIDTH(8), .ROUNDS(1)) u0 (
        .clock(clock), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_data(din[0][7:0]), .in_key(key[0][7:0]), .in_mode(md[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(o0));
    feistel_cipher_iter #(.WIDTH(8), .ROUNDS(4)) u1 (
        .clock(clock), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_data(din[1][7:0]), .in_key(key[1][7:0]), .in_mode(md[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(o1));
    feistel_cipher_iter #(.WIDTH(16), .ROUNDS(7)) u2 (
        .clock(clock), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_data(din[2]), .in_key(key[2]), .in_mode(md[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(o2));

    function automatic logic [15:0] dout(input int u);
        return u == 0 ? {8'h0, o0} : u == 1 ? {8'h0, o1} : o2;
    endfunction

    function automatic int wof(input int u);
        return u == 2 ? 16 : 8;
    endfunction

    function automatic int rof(input int u);
        return u == 0 ? 1 : u == 1 ? 4 : 7;
    endfunction

    function automatic logic [15:0] model(input int w, input int rn, input logic [15:0] d,
                                          input logic [15:0] k, input logic dec);
        int h, mh, mw, di, ki, l, r, t, s, kj, e, x, f;
        h  = w / 2;
        mh = (1 << h) - 1;
        mw = (1 << w) - 1;
        di = int'(d) & mw;
        ki = int'(k) & mw;
        if (WH) di = di ^ ki;
        l = dec ? di & mh : di >> h;
        r = dec ? di >> h : di & mh;
        for (int i = 0; i < rn; i++) begin
            s  = (dec ? rn - 1 - i : i) % w;
            kj = ((ki << s) | (ki >> (w - s))) & mw;
            e  = ((((r << 1) | (r >> (h - 1))) & mh) << h) | r;
            x  = e ^ kj;
            f  = ((x >> h) + (x & mh) + (kj & 1)) & mh;
            t  = l ^ f;
            l  = r;
            r  = t;
        end
        t = dec ? (r << h) | l : (l << h) | r;
        if (WH) t = t ^ ki;
        return 16'(t);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic start(input int u, input logic [15:0] d, input logic [15:0] k, input logic m);
        int t = 0;
        while (!ir[u] && t < 50) begin
            @(posedge clock); #1;
            t++;
        end
        chk("in_ready before accept", 32'(ir[u]), 1);
        din[u] = d;
        key[u] = k;
        md[u]  = m;
        iv[u]  = 1'b1;
        @(posedge clock); #1;
        iv[u]  = 1'b0;
    endtask

    task automatic wait_done(input int u);
        int t = 0;
        while (!ov[u] && t < 50) begin
            chk("in_ready low while busy", 32'(ir[u]), 0);
            @(posedge clock); #1;
            t++;
        end
        chk("latency", t, rof(u));
    endtask

    task automatic take(input int u);
        ordy[u] = 1'b1;
        @(posedge clock); #1;
        ordy[u] = 1'b0;
        chk("idle after handshake", {30'd0, ov[u], ir[u]}, 1);
    endtask

    task automatic run(input int u, input logic [15:0] d, input logic [15:0] k, input logic m,
                       output logic [15:0] res);
        start(u, d, k, m);
        wait_done(u);
        res = dout(u);
        take(u);
    endtask

    initial begin
        logic [15:0] c, p, d, k, e, mk;
        for (int i = 0; i < 3; i++) begin
            din[i] = '0;
            key[i] = '0;
        end
        #2;
        chk("reset out_valid", 32'(ov), 0);
        chk("reset in_ready", 32'(ir), 0);
        chk("reset out_data", {o2, o1, o0}, 0);
        #10 reset = 1'b1;
        #1 chk("in_ready before first edge", 32'(ir), 0);
        @(posedge clock); #1;
        chk("in_ready after first edge", 32'(ir), 7);

`ifndef FEISTEL_KEY_WHITEN_EN
        run(0, 16'h46, 16'h93, 1'b0, c); chk("r1 enc 46/93", c, 16'h6F);
        run(0, 16'h6F, 16'h93, 1'b1, c); chk("r1 dec 6f/93", c, 16'h46);
        run(1, 16'h46, 16'h93, 1'b0, c); chk("r4 enc 46/93", c, 16'hD3);
        run(1, 16'hD3, 16'h93, 1'b1, c); chk("r4 dec d3/93", c, 16'h46);
`endif
        run(0, 16'h00, 16'h00, 1'b0, c); chk("r1 enc zero", c, 16'h00);
        run(1, 16'h00, 16'h00, 1'b0, c); chk("r4 enc zero", c, 16'h00);

        for (int n = 0; n < 270; n++) begin
            int u;
            u  = n < 200 ? 1 : n < 240 ? 2 : 0;
            mk = u == 2 ? 16'hFFFF : 16'h00FF;
            d  = 16'($urandom) & mk;
            k  = 16'($urandom) & mk;
            run(u, d, k, 1'b0, c);
            chk("random encrypt", c, model(wof(u), rof(u), d, k, 1'b0));
            run(u, c, k, 1'b1, p);
            chk("round trip", p, d);
        end

        e = model(8, 4, 16'h5A, 16'h3C, 1'b0);
        start(1, 16'h5A, 16'h3C, 1'b0);
        wait_done(1);
        din[1] = 16'hA5;
        key[1] = 16'h11;
        iv[1]  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            chk("bp out_valid", 32'(ov[1]), 1);
            chk("bp out_data", dout(1), e);
            chk("bp in_ready", 32'(ir[1]), 0);
        end
        iv[1] = 1'b0;
        take(1);
        run(1, 16'hA5, 16'h11, 1'b0, c);
        chk("bp next block", c, model(8, 4, 16'hA5, 16'h11, 1'b0));

        run(1, 16'h46, 16'h93, 1'b0, c);
        chk("pre-reset result", c, model(8, 4, 16'h46, 16'h93, 1'b0));
        start(1, 16'h77, 16'h21, 1'b0);
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        chk("mid-reset out_valid", 32'(ov[1]), 0);
        chk("mid-reset out_data", dout(1), 0);
        chk("mid-reset in_ready", 32'(ir[1]), 0);
        #2 reset = 1'b1;
        @(posedge clock); #1;
        chk("post-reset in_ready", 32'(ir[1]), 1);
        chk("post-reset out_valid", 32'(ov[1]), 0);
        run(1, 16'hD3, 16'h93, 1'b1, c);
        chk("post-reset block", c, model(8, 4, 16'hD3, 16'h93, 1'b1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
